// File: rtl/extmem_pkg.sv
// Shared types for the external SRAM arbiter: sequencer states, owner encoding, widths
// and the latched access descriptor handed from arbiter to sequencer.
package extmem_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_P0 = 1'b0,
    OWN_P1 = 1'b1
  } owner_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/extmem_if.sv
// Requester handshakes for both ports plus the external SRAM pins.
// slave = arbiter side, master = requesters and SRAM device side.
interface extmem_if;
  import extmem_pkg::*;

  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_done;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_done;

  logic [ADDR_W-1:0] sram_ad;
  logic [DATA_W-1:0] sram_dq_i;
  logic [DATA_W-1:0] sram_dq_o;
  logic              sram_dq_oe;
  logic              sram_cs;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic              busy;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  sram_dq_i,
    output p0_rdata, p0_done, p1_rdata, p1_done,
    output sram_ad, sram_dq_o, sram_dq_oe, sram_cs, sram_oe_n, sram_we_n, busy
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output sram_dq_i,
    input  p0_rdata, p0_done, p1_rdata, p1_done,
    input  sram_ad, sram_dq_o, sram_dq_oe, sram_cs, sram_oe_n, sram_we_n, busy
  );

endinterface

// File: rtl/extmem_seq.sv
// SRAM access sequencer: SETUP / STROBE x STROBE_CYCLES / HOLD, drives the SRAM pins.
// Latency start->done = STROBE_CYCLES+2 clks; start is only taken in IDLE (busy=1 otherwise).
module extmem_seq
  import extmem_pkg::*;
#(
  parameter int STROBE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_vld,
  input  req_t              start_dat,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sram_ad,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  output logic              sram_cs,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam logic [3:0] LAST_STROBE = 4'(STROBE_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  req_t              acc_q, acc_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (start_vld) begin
          state_d    = ST_SETUP;
          cnt_d      = '0;
          acc_d.we   = start_dat.we;
          acc_d.addr = start_dat.addr;
          // Reads leave the last write data on dq_o so the undriven bus does not toggle.
          if (start_dat.we) begin
            acc_d.wdata = start_dat.wdata;
          end
        end
      end
      ST_SETUP: state_d = ST_STROBE;
      ST_STROBE: begin
        if (cnt_q == LAST_STROBE) begin
          state_d = ST_HOLD;
          if (!acc_q.we) begin
            rdata_d = sram_dq_i;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    done       = 1'b0;
    sram_cs    = 1'b0;
    sram_dq_oe = 1'b0;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    case (state_q)
      ST_SETUP: begin
        sram_cs    = 1'b1;
        sram_dq_oe = acc_q.we;
      end
      ST_STROBE: begin
        sram_cs    = 1'b1;
        sram_dq_oe = acc_q.we;
        sram_oe_n  = acc_q.we;
        sram_we_n  = !acc_q.we;
      end
      ST_HOLD: begin
        sram_cs    = 1'b1;
        sram_dq_oe = acc_q.we;
        done       = 1'b1;
      end
      default: ;
    endcase
  end

  assign sram_ad   = acc_q.addr;
  assign sram_dq_o = acc_q.wdata;
  assign rdata     = rdata_q;

endmodule

// File: rtl/extmem_arbiter.sv
// Two-port arbiter onto one 128Kx8 SRAM; port 0 has priority, EXTMEM_FAIR_EN bounds port-1 starvation.
// Grant->done = STROBE_CYCLES+2 clks, one IDLE clk between accesses; requesters hold pX_req until pX_done.
// Losing requester simply waits with its request held; there is no abort path.
module extmem_arbiter
  import extmem_pkg::*;
#(
  parameter int STROBE_CYCLES = 2,
  parameter int MAX_WAIT      = 8
) (
  input logic     clk,
  input logic     rst,
  extmem_if.slave bus
);

  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
    $error("extmem_arbiter: STROBE_CYCLES must be 1..15");
  end
  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_wait
    $error("extmem_arbiter: MAX_WAIT must be 1..15");
  end

  logic              seq_busy;
  logic              seq_done;
  logic [DATA_W-1:0] seq_rdata;
  logic              start_vld;
  req_t              start_dat;
  logic              pick_p1;
  logic              p1_due;
  owner_t            owner_q, owner_d;
  logic              rd_q, rd_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic              p0_done, p1_done;

`ifdef EXTMEM_FAIR_EN
  // Consecutive port-0 grants taken while port 1 was waiting.
  logic [3:0] wait_q, wait_d;

  assign p1_due = (wait_q >= 4'(MAX_WAIT));

  always_comb begin
    wait_d = wait_q;
    if (!bus.p1_req) begin
      wait_d = '0;
    end else if (start_vld) begin
      if (pick_p1) begin
        wait_d = '0;
      end else if (wait_q != 4'hF) begin
        wait_d = wait_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign p1_due = 1'b0;
`endif

  // Sequencer idle means no done pulse this clk, so a requester that just finished cannot re-win here.
  always_comb begin
    start_vld = !seq_busy && (bus.p0_req || bus.p1_req);
    pick_p1   = bus.p1_req && (!bus.p0_req || p1_due);
    if (pick_p1) begin
      start_dat.we    = bus.p1_we;
      start_dat.addr  = bus.p1_addr;
      start_dat.wdata = bus.p1_wdata;
    end else begin
      start_dat.we    = bus.p0_we;
      start_dat.addr  = bus.p0_addr;
      start_dat.wdata = bus.p0_wdata;
    end
    owner_d = owner_q;
    rd_d    = rd_q;
    if (start_vld) begin
      owner_d = pick_p1 ? OWN_P1 : OWN_P0;
      rd_d    = !start_dat.we;
    end
  end

  always_comb begin
    p0_done    = seq_done && (owner_q == OWN_P0);
    p1_done    = seq_done && (owner_q == OWN_P1);
    p0_rdata_d = (p0_done && rd_q) ? seq_rdata : p0_rdata_q;
    p1_rdata_d = (p1_done && rd_q) ? seq_rdata : p1_rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q    <= OWN_P0;
      rd_q       <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      owner_q    <= owner_d;
      rd_q       <= rd_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  extmem_seq #(
    .STROBE_CYCLES(STROBE_CYCLES)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .start_vld (start_vld),
    .start_dat (start_dat),
    .sram_dq_i (bus.sram_dq_i),
    .busy      (seq_busy),
    .done      (seq_done),
    .rdata     (seq_rdata),
    .sram_ad   (bus.sram_ad),
    .sram_dq_o (bus.sram_dq_o),
    .sram_dq_oe(bus.sram_dq_oe),
    .sram_cs   (bus.sram_cs),
    .sram_oe_n (bus.sram_oe_n),
    .sram_we_n (bus.sram_we_n)
  );

  assign bus.p0_done  = p0_done;
  assign bus.p1_done  = p1_done;
  assign bus.p0_rdata = p0_rdata_d;
  assign bus.p1_rdata = p1_rdata_d;
  assign bus.busy     = seq_busy;

endmodule
